reg_file_mp: RTL and testbench



---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_clr_seq.sv | 67 ++++++
 rtl/reg_file_mp.sv | 84 ++++++++
 tb/tb_reg_file_mp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and sizing helper for the multi-read-port register file
package reg_file_pkg;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  function automatic int calc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// rtl/reg_file_clr_seq.sv - runtime clear sequencer: sweeps one entry per cycle, blocks external writes
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  w_ready,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  sweep_en,
  output logic [ADDR_WIDTH-1:0] sweep_addr
);

  localparam int DEPTH = calc_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= done_nxt;
    end
  end

  // cnt parks on the last address after a sweep rather than wrapping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready    = (state == IDLE);
    clr_busy   = (state == CLEAR);
    sweep_en   = (state == CLEAR);
    sweep_addr = cnt;
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - register file with one sync write port and NUM_RD async read ports
// Optional write-first forwarding on read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_RD     = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    w_en,
  input  logic        [ADDR_WIDTH-1:0]            w_addr,
  input  logic signed [DATA_WIDTH-1:0]            w_data,
  output logic                                    w_ready,
  input  logic        [NUM_RD-1:0][ADDR_WIDTH-1:0] r_addr,
  output logic signed [NUM_RD-1:0][DATA_WIDTH-1:0] r_data,
  input  logic                                    clr_start,
  output logic                                    clr_busy,
  output logic                                    clr_done
);

  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic                         sweep_en;
  logic        [ADDR_WIDTH-1:0] sweep_addr;
  logic                         ext_we;
  logic                         wr_en;
  logic        [ADDR_WIDTH-1:0] wr_addr;
  logic signed [DATA_WIDTH-1:0] wr_data;

  reg_file_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_start  (clr_start),
    .w_ready    (w_ready),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr)
  );

  assign ext_we = w_en && w_ready;

  // Sweep and external writes never coincide: w_ready is low throughout a sweep
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = w_addr;
    wr_data = w_data;
    if (sweep_en) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr;
      wr_data = '0;
    end else if (ext_we) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      r_data[i] = mem[r_addr[i]];
`ifdef REG_FILE_BYPASS_EN
      if (ext_we && (r_addr[i] == w_addr)) begin
        r_data[i] = w_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;

  logic                   clk;
  logic                   rst_n;
  logic                   w_en;
  logic [1:0]             w_addr;
  logic signed [7:0]      w_data;
  logic                   w_ready;
  logic [1:0][1:0]        r_addr;
  logic signed [1:0][7:0] r_data;
  logic                   clr_start;
  logic                   clr_busy;
  logic                   clr_done;

  int n_pass;
  int n_total;

  reg_file_mp #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .NUM_RD     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    w_en   = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int a = 0; a < 4; a++) begin
      r_addr[0] = 2'(a);
      r_addr[1] = 2'(3 - a);
      #1;
      n_total++;
      if (r_data[0] !== 8'h00) $display("FAIL reset_p0 addr %0d: got %h want 00", a, r_data[0]);
      else n_pass++;
      n_total++;
      if (r_data[1] !== 8'h00) $display("FAIL reset_p1 addr %0d: got %h want 00", 3 - a, r_data[1]);
      else n_pass++;
    end
    n_total++;
    if ({w_ready, clr_busy, clr_done} !== 3'b100)
      $display("FAIL reset_status: got ready/busy/done %b want 100", {w_ready, clr_busy, clr_done});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed();
    do_write(2'd1, 8'h7F);
    do_write(2'd2, 8'h80);
    r_addr = {2'd1, 2'd2};
    #1;
    n_total++;
    if ($signed(r_data[1]) !== 8'sd127) $display("FAIL signed_max: got %0d want 127", $signed(r_data[1]));
    else n_pass++;
    n_total++;
    if ($signed(r_data[0]) !== -8'sd128) $display("FAIL signed_min: got %0d want -128", $signed(r_data[0]));
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [7:0] exp_same;
`ifdef REG_FILE_BYPASS_EN
    exp_same = 8'h55;
`else
    exp_same = 8'h00;
`endif
    r_addr[0] = 2'd3;
    r_addr[1] = 2'd1;
    w_en   = 1'b1;
    w_addr = 2'd3;
    w_data = 8'h55;
    #1;
    n_total++;
    if (r_data[0] !== exp_same) $display("FAIL bypass_same_cycle: got %h want %h", r_data[0], exp_same);
    else n_pass++;
    n_total++;
    if (r_data[1] !== 8'h7F) $display("FAIL bypass_other_port: got %h want 7f", r_data[1]);
    else n_pass++;
    tick();
    w_en = 1'b0;
    #1;
    n_total++;
    if (r_data[0] !== 8'h55) $display("FAIL write_visible: got %h want 55", r_data[0]);
    else n_pass++;
  endtask

  task automatic test_clear_sweep();
    logic [7:0] fill [4];
    logic [7:0] exp;
    int busy_cnt;
    int done_cnt;
    fill = '{8'h31, 8'h42, 8'h53, 8'h64};
    for (int a = 0; a < 4; a++) do_write(2'(a), fill[a]);
    busy_cnt = 0;
    done_cnt = 0;
    clr_start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j == 0) begin
        clr_start = 1'b0;
        w_en      = 1'b1;
        w_addr    = 2'd0;
        w_data    = 8'h99;
      end
      if (j == 4) w_en = 1'b0;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      n_total++;
      if (clr_done !== (j == 4)) $display("FAIL clr_done_timing j=%0d: got %b want %b", j, clr_done, (j == 4));
      else n_pass++;
      n_total++;
      if (w_ready !== (j > 3)) $display("FAIL w_ready_sweep j=%0d: got %b want %b", j, w_ready, (j > 3));
      else n_pass++;
      for (int a = 0; a < 4; a++) begin
        r_addr[0] = 2'(a);
        r_addr[1] = 2'(a);
        #1;
        exp = (j >= a + 1) ? 8'h00 : fill[a];
        n_total++;
        if (r_data[0] !== exp || r_data[1] !== exp)
          $display("FAIL sweep_entry j=%0d addr %0d: got %h/%h want %h", j, a, r_data[0], r_data[1], exp);
        else n_pass++;
      end
    end
    n_total++;
    if (busy_cnt !== 4) $display("FAIL clr_busy_cycles: got %0d want 4", busy_cnt);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL clr_done_count: got %0d want 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_start_with_write();
    int busy_cnt;
    int done_cnt;
    busy_cnt  = 0;
    done_cnt  = 0;
    r_addr[0] = 2'd3;
    clr_start = 1'b1;
    w_en      = 1'b1;
    w_addr    = 2'd3;
    w_data    = 8'h11;
    tick();
    w_en = 1'b0;
    #1;
    n_total++;
    if (r_data[0] !== 8'h11) $display("FAIL start_write_accepted: got %h want 11", r_data[0]);
    else n_pass++;
    for (int j = 0; j < 7; j++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (j == 3) clr_start = 1'b0;
      tick();
    end
    n_total++;
    if (busy_cnt !== 4) $display("FAIL restart_ignored_busy: got %0d want 4", busy_cnt);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL restart_ignored_done: got %0d want 1", done_cnt);
    else n_pass++;
    n_total++;
    if (r_data[0] !== 8'h00) $display("FAIL start_write_overwritten: got %h want 00", r_data[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    logic done_seen;
    for (int a = 0; a < 3; a++) do_write(2'(a), 8'h0A + 8'(a));
    do_write(2'd3, 8'h22);
    r_addr[0] = 2'd3;
    r_addr[1] = 2'd2;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    n_total++;
    if (r_data[0] !== 8'h22 || clr_busy !== 1'b1)
      $display("FAIL pre_reset_state: got %h busy %b want 22 busy 1", r_data[0], clr_busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (r_data[0] !== 8'h00 || r_data[1] !== 8'h00)
      $display("FAIL mid_reset_entries: got %h/%h want 00/00", r_data[0], r_data[1]);
    else n_pass++;
    n_total++;
    if ({w_ready, clr_busy, clr_done} !== 3'b100)
      $display("FAIL mid_reset_status: got %b want 100", {w_ready, clr_busy, clr_done});
    else n_pass++;
    done_seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j == 2) rst_n = 1'b1;
      tick();
      if (clr_done || clr_busy) done_seen = 1'b1;
    end
    n_total++;
    if (done_seen !== 1'b0) $display("FAIL mid_reset_no_done: got %b want 0", done_seen);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    w_en      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    r_addr    = '0;
    clr_start = 1'b0;
    test_reset();
    test_signed();
    test_bypass();
    test_clear_sweep();
    test_start_with_write();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
